// File: rtl/lsu_rmw.sv
// RV32I load/store unit in front of a word-wide synchronous-read RAM.
// Sub-word stores become a read (IDLE) followed by a merged write (MERGE).
module lsu_rmw #(
  parameter int addr_width = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  load_valid,
  output logic [31:0]           load_data,
  output logic                  misaligned,
  output logic [addr_width-1:0] daddr,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [31:0]           ddata_w,
  input  logic [31:0]           ddata_r
);

  typedef enum logic {IDLE, MERGE} state_t;
  state_t state;

  function automatic logic [31:0] ld_extend(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'd0, b} : 32'(b);
      2'b01:   r = f3[2] ? {16'd0, h} : 32'(h);
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [1:0] off,
                                           input logic half, input logic [15:0] wd);
    logic [31:0] r;
    r = w;
    if (half) begin
      if (off[1]) r[31:16] = wd;
      else        r[15:0]  = wd;
    end else begin
      r[{off, 3'b000} +: 8] = wd[7:0];
    end
    return r;
  endfunction

  logic is_w, is_h, f3_legal, mis_c, acc_c, sub_st_c;
  logic                  vld_p1, mis_p1, half_p1;
  logic [1:0]            off_p1;
  logic [2:0]            f3_p1;
  logic [addr_width-1:0] addr_p1;
  logic [15:0]           wd_p1;
  logic [31:0]           ld_ext_p1, ld_hold_p1;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:addr_width+2];

  always_comb begin
    is_w     = (req_funct3 == 3'b010);
    is_h     = (req_funct3[1:0] == 2'b01);
    // Stores only know B/H/W; loads add the unsigned BU/HU forms.
    f3_legal = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                         : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    mis_c    = req_valid && f3_legal && ((is_w && req_addr[1:0] != 2'b00) || (is_h && req_addr[0]));
    acc_c    = req_valid && f3_legal && !mis_c && (state == IDLE) && !RESET;
    sub_st_c = acc_c && req_write && !is_w;
  end

  // Stage 0: RAM request, combinational from the core or from the held store
  always_comb begin
    daddr    = '0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ddata_w  = '0;
    stall    = 1'b0;
    if (!RESET) begin
      if (state == MERGE) begin
        daddr    = addr_p1;
        MemWrite = 1'b1;
        ddata_w  = st_merge(ddata_r, off_p1, half_p1, wd_p1);
      end else if (acc_c) begin
        daddr = req_addr[addr_width+1:2];
        if (!req_write) begin
          MemRead = 1'b1;
        end else if (is_w) begin
          MemWrite = 1'b1;
          ddata_w  = req_wdata;
        end else begin
          MemRead = 1'b1;
          stall   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      vld_p1     <= 1'b0;
      mis_p1     <= 1'b0;
      ld_hold_p1 <= '0;
    end else begin
      vld_p1 <= acc_c && !req_write;
      mis_p1 <= mis_c && (state == IDLE);
      if (vld_p1) ld_hold_p1 <= ld_ext_p1;
      case (state)
        IDLE:    if (sub_st_c) state <= MERGE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (acc_c) begin
      off_p1  <= req_addr[1:0];
      f3_p1   <= req_funct3;
      addr_p1 <= req_addr[addr_width+1:2];
      wd_p1   <= req_wdata[15:0];
      half_p1 <= req_funct3[0];
    end
  end

  // Stage 1: RAM data returns; extract now, hold afterwards
  assign ld_ext_p1  = ld_extend(ddata_r, off_p1, f3_p1);
  assign load_valid = vld_p1 && !RESET;
  assign load_data  = RESET ? 32'd0 : (vld_p1 ? ld_ext_p1 : ld_hold_p1);
  assign misaligned = mis_p1 && !RESET;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a behavioural synchronous-read word RAM.
module tb_lsu_rmw;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, load_valid, misaligned, MemRead, MemWrite;
  logic [31:0] load_data, ddata_w;
  logic [31:0] ddata_r = '0;
  logic [9:0]  daddr;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int total = 0, bad = 0;

  lsu_rmw #(.addr_width(10)) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_valid(load_valid), .load_data(load_data), .misaligned(misaligned),
    .daddr(daddr), .MemRead(MemRead), .MemWrite(MemWrite), .ddata_w(ddata_w), .ddata_r(ddata_r)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (MemWrite) mem[daddr] <= ddata_w;
    if (MemRead) ddata_r <= mem[daddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    cyc();
    req_valid = 1'b0;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    cyc();
    pl_en = 1'b0;
  endtask

  task automatic req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    cyc();
    req(1'b0, f3, a, 32'd0);
    #4;
    chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    chk({tag, ".rd"}, {31'd0, MemRead}, 32'd1);
    cyc();
    req_valid = 1'b0;
    #4;
    chk({tag, ".vld"}, {31'd0, load_valid}, 32'd1);
    chk({tag, ".data"}, load_data, exp);
  endtask

  task automatic do_sub(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_w);
    cyc();
    req(1'b1, f3, a, wd);
    #4;
    chk({tag, ".stall1"}, {31'd0, stall}, 32'd1);
    chk({tag, ".rd"}, {31'd0, MemRead}, 32'd1);
    chk({tag, ".wr0"}, {31'd0, MemWrite}, 32'd0);
    cyc();
    #4;
    chk({tag, ".stall2"}, {31'd0, stall}, 32'd0);
    chk({tag, ".wr1"}, {31'd0, MemWrite}, 32'd1);
    chk({tag, ".addr"}, {22'd0, daddr}, {22'd0, a[11:2]});
    chk({tag, ".wdata"}, ddata_w, exp_w);
  endtask

  initial begin
    req(1'b0, 3'b010, 32'h14, 32'd0);
    cyc();
    #4;
    chk("rst.vld", {31'd0, load_valid}, 32'd0);
    chk("rst.data", load_data, 32'd0);
    chk("rst.mis", {31'd0, misaligned}, 32'd0);
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.rd", {31'd0, MemRead}, 32'd0);
    chk("rst.wr", {31'd0, MemWrite}, 32'd0);
    cyc();
    RESET = 1'b0;
    req_valid = 1'b0;

    preload(10'd5, 32'h8421_F0A5);
    preload(10'd2, 32'h1122_3344);
    preload(10'd3, 32'hCAFE_0123);
    preload(10'd0, 32'hA0A0_0001);
    preload(10'd1, 32'hB1B1_0002);

    do_load("lw", 3'b010, 32'h14, 32'h8421_F0A5);
    do_load("lb", 3'b000, 32'h14, 32'hFFFF_FFA5);
    do_load("lbu", 3'b100, 32'h15, 32'h0000_00F0);
    do_load("lh", 3'b001, 32'h16, 32'hFFFF_8421);
    do_load("lhu", 3'b101, 32'h16, 32'h0000_8421);
    cyc();
    #4;
    chk("hold.vld", {31'd0, load_valid}, 32'd0);
    chk("hold.data", load_data, 32'h0000_8421);
    do_load("wrap", 3'b010, 32'h0000_1014, 32'h8421_F0A5);

    do_sub("sb", 3'b000, 32'h09, 32'hFFFF_FFAB, 32'h1122_AB44);
    do_load("lw_after_sb", 3'b010, 32'h08, 32'h1122_AB44);

    preload(10'd2, 32'd0);
    do_sub("sh", 3'b001, 32'h0A, 32'h0000_BEEF, 32'hBEEF_0000);
    cyc();
    req_valid = 1'b0;
    chk("sh.ram", mem[2], 32'hBEEF_0000);

    cyc();
    req(1'b1, 3'b001, 32'h0B, 32'h0000_1234);
    #4;
    chk("mis.rd", {31'd0, MemRead}, 32'd0);
    chk("mis.wr", {31'd0, MemWrite}, 32'd0);
    chk("mis.stall", {31'd0, stall}, 32'd0);
    cyc();
    req_valid = 1'b0;
    #4;
    chk("mis.pulse", {31'd0, misaligned}, 32'd1);
    chk("mis.vld", {31'd0, load_valid}, 32'd0);
    cyc();
    #4;
    chk("mis.clear", {31'd0, misaligned}, 32'd0);
    chk("mis.ram", mem[2], 32'hBEEF_0000);

    cyc();
    req(1'b0, 3'b011, 32'h14, 32'd0);
    #4;
    chk("undef.rd", {31'd0, MemRead}, 32'd0);
    cyc();
    req_valid = 1'b0;
    #4;
    chk("undef.mis", {31'd0, misaligned}, 32'd0);
    chk("undef.vld", {31'd0, load_valid}, 32'd0);

    cyc();
    req(1'b0, 3'b010, 32'h00, 32'd0);
    #4;
    chk("b2b.rd0", {31'd0, MemRead}, 32'd1);
    cyc();
    req(1'b0, 3'b010, 32'h04, 32'd0);
    #4;
    chk("b2b.vld0", {31'd0, load_valid}, 32'd1);
    chk("b2b.data0", load_data, 32'hA0A0_0001);
    chk("b2b.stall0", {31'd0, stall}, 32'd0);
    cyc();
    req(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF);
    #4;
    chk("b2b.vld1", {31'd0, load_valid}, 32'd1);
    chk("b2b.data1", load_data, 32'hB1B1_0002);
    chk("sw.wr", {31'd0, MemWrite}, 32'd1);
    chk("sw.wdata", ddata_w, 32'hDEAD_BEEF);
    chk("sw.stall", {31'd0, stall}, 32'd0);
    cyc();
    req_valid = 1'b0;
    #4;
    chk("sw.ram", mem[2], 32'hDEAD_BEEF);
    chk("sw.vld", {31'd0, load_valid}, 32'd0);

    cyc();
    req(1'b1, 3'b000, 32'h0C, 32'h0000_0055);
    #4;
    chk("rmw_rst.stall1", {31'd0, stall}, 32'd1);
    cyc();
    RESET = 1'b1;
    #4;
    chk("rmw_rst.wr", {31'd0, MemWrite}, 32'd0);
    chk("rmw_rst.rd", {31'd0, MemRead}, 32'd0);
    chk("rmw_rst.stall", {31'd0, stall}, 32'd0);
    chk("rmw_rst.data", load_data, 32'd0);
    chk("rmw_rst.vld", {31'd0, load_valid}, 32'd0);
    chk("rmw_rst.mis", {31'd0, misaligned}, 32'd0);
    cyc();
    RESET = 1'b0;
    req_valid = 1'b0;
    chk("rmw_rst.ram", mem[3], 32'hCAFE_0123);
    do_load("lw_after_rst", 3'b010, 32'h0C, 32'hCAFE_0123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit placed between the pipelined core's MEM stage and the word-wide, synchronous-read data RAM (ports CLK, daddr, MemWrite, MemRead, ddata_w, ddata_r; no byte enables).
- Translates RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into RAM word accesses.
- Sub-word stores use a 2-cycle read-modify-write.
- Load data is extracted and sign- or zero-extended, and misaligned accesses are flagged.

Parameters:
- addr_width, 10, RAM word-address width; byte address bits [addr_width+1:2] select the word.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  memory request present this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- stall  out  1  core must hold its request and freeze upstream stages.
- load_valid  out  1  load_data valid (cycle after load acceptance).
- load_data  out  32  extended load result.
- misaligned  out  1  one-cycle pulse, cycle after a misaligned request.
- daddr  out  addr_width  RAM word address.
- MemRead  out  1  RAM read enable.
- MemWrite  out  1  RAM write enable.
- ddata_w  out  32  RAM write data.
- ddata_r  in  32  RAM read data, valid one cycle after MemRead.

Behaviour:
- FSM states: IDLE, MERGE.
- RAM-side outputs are combinational from the inputs (IDLE) or from registered request copies (MERGE). All are 0 while RESET=1.

Alignment:
- Misaligned means W/SW with addr[1:0]!=0, or H/HU/SH with addr[0]=1.
- A misaligned access causes no RAM access and pulses misaligned=1 in the next cycle; load_valid stays 0.
- Undefined funct3 (011, 110, 111): no access, no flags.

IDLE, aligned load:
- MemRead=1, daddr=req_addr[addr_width+1:2], stall=0.
- Register the byte offset and funct3.
- Next cycle: load_valid=1.
- B/BU: load_data = byte at offset (lane k = bits 8k+7:8k), sign-/zero-extended.
- H/HU: load_data = half at offset[1] (lane 0 = bits 15:0, lane 1 = 31:16), extended.
- W: load_data = ddata_r.
- Back-to-back loads run at one per cycle.

IDLE, aligned SW:
- MemWrite=1 and ddata_w=req_wdata in the same cycle, stall=0.

IDLE, aligned SB/SH:
- MemRead=1, stall=1.
- Register the word address, offset, size and wdata; go to MERGE.

MERGE:
- daddr = registered address; MemWrite=1.
- ddata_w = ddata_r with the target byte or half lane replaced by the registered data; other lanes unchanged.
- stall=0; return to IDLE.
- Request inputs are ignored in MERGE (the core is still presenting the held request).
- Total latency of SB/SH is 2 cycles.

Ordering:
- A load accepted in the cycle after MERGE reads the merged value, because the write completes on the MERGE edge.

Registered outputs:
- load_valid, load_data and misaligned are registered.
- Reset values: load_valid=0, load_data=0, misaligned=0, state=IDLE.
- load_data holds its last value when load_valid=0.

Reset:
- RESET in any cycle forces IDLE and clears all registered outputs.
- Reset during MERGE aborts the store: MemWrite=0 and the RAM word is left unmodified.
- stall=0 during reset.

Address:
- req_addr bits above addr_width+1 are ignored (wrap-around into RAM).

Test Plan:
- RAM[5]=32'h8421_F0A5; LW addr 0x14 -> next cycle load_valid=1, load_data=32'h8421_F0A5, stall never 1.
- Same word; LB 0x14 -> 32'hFFFF_FFA5. LBU 0x15 -> 32'h0000_00F0. LH 0x16 -> 32'hFFFF_8421. LHU 0x16 -> 32'h0000_8421.
- RAM[2]=32'h1122_3344; SB addr 0x09 wdata 32'hFFFF_FFAB -> stall=1 for one cycle, MemWrite in MERGE with ddata_w=32'h1122_AB44; following LW 0x08 returns 32'h1122_AB44.
- SH addr 0x0A wdata 32'h0000_BEEF on RAM[2]=0 -> RAM[2]=32'hBEEF_0000. SH addr 0x0B -> misaligned=1 next cycle, no MemRead/MemWrite, RAM unchanged.
- LW 0x00, LW 0x04, SW 0x08 (wdata 32'hDEAD_BEEF) on consecutive cycles -> two consecutive load_valid pulses with correct data, and RAM[2]=32'hDEAD_BEEF without stall.
- SB 0x0C issued; RESET=1 in the MERGE cycle -> MemWrite=0, RAM[3] unchanged, all outputs 0. After release, LW 0x0C returns the original value.
